apa102_strip_rx: RTL and testbench

//   Receive end of the serial LED-strip link driven by our matrix controller.

---
 rtl/apa102_strip_rx.sv | 161 ++++++++++++++++
 tb/tb_apa102_strip_rx.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apa102_strip_rx.sv
// APA102-style strip receiver: decodes the sclk/sdata LED stream into pixel
// writes, frame-end pulses and protocol-error pulses in the clk domain.
module apa102_strip_rx #(
    parameter int NUM_LEDS       = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sclk_in,
    input  logic                          sdata_in,
    output logic                          pix_we,
    output logic [$clog2(NUM_LEDS)-1:0]   pix_addr,
    output logic [4:0]                    pix_bright,
    output logic [23:0]                   pix_rgb,
    output logic                          frame_done,
    output logic [$clog2(NUM_LEDS):0]     frame_leds,
    output logic                          overflow,
    output logic                          proto_err,
    output logic                          synced
);

    localparam int AW = $clog2(NUM_LEDS);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;

    localparam logic [AW:0]   LED_LIMIT = (AW+1)'(NUM_LEDS);
    localparam logic [AW:0]   LED_SAT   = '1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic          sclk_s1, sclk_s2, sclk_prev;
    logic          sdata_s1, sdata_s2;
    logic [1:0]    state;
    logic [31:0]   shift_reg;
    logic [4:0]    bit_cnt;
    logic [5:0]    zero_cnt;
    logic [AW:0]   led_cnt;
    logic [TW-1:0] timeout_cnt;

    logic          sclk_edge;
    logic          bit_val;
    logic [31:0]   word_next;

    assign sclk_edge = sclk_s2 & ~sclk_prev;
    assign bit_val   = sdata_s2;
    assign word_next = {shift_reg[30:0], bit_val};
    assign synced    = (state == ST_IDLE) || (state == ST_FRAME);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the synchronizer flops are reset too, so an sclk that is high
            // when reset drops shows up as one edge and therefore one bit.
            sclk_s1     <= 1'b0;
            sclk_s2     <= 1'b0;
            sclk_prev   <= 1'b0;
            sdata_s1    <= 1'b0;
            sdata_s2    <= 1'b0;
            state       <= ST_HUNT;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            zero_cnt    <= '0;
            led_cnt     <= '0;
            timeout_cnt <= '0;
            pix_we      <= 1'b0;
            pix_addr    <= '0;
            pix_bright  <= '0;
            pix_rgb     <= '0;
            frame_done  <= 1'b0;
            frame_leds  <= '0;
            overflow    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            sclk_s1    <= sclk_in;
            sclk_s2    <= sclk_s1;
            sclk_prev  <= sclk_s2;
            sdata_s1   <= sdata_in;
            sdata_s2   <= sdata_s1;
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            proto_err  <= 1'b0;

            case (state)
                ST_HUNT: begin
                    timeout_cnt <= '0;
                    if (sclk_edge) begin
                        if (bit_val) begin
                            zero_cnt <= '0;
                        end else if (zero_cnt == 6'd31) begin
                            zero_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            zero_cnt <= zero_cnt + 6'd1;
                        end
                    end
                end

                ST_IDLE: begin
                    timeout_cnt <= '0;
                    if (sclk_edge && bit_val) begin
                        shift_reg <= 32'd1;
                        bit_cnt   <= 5'd1;
                        led_cnt   <= '0;
                        overflow  <= 1'b0;
                        state     <= ST_FRAME;
                    end
                end

                ST_FRAME: begin
                    if (sclk_edge) begin
                        timeout_cnt <= '0;
                        shift_reg   <= word_next;
                        if (bit_cnt == 5'd31) begin
                            bit_cnt <= '0;
                            if (word_next[31:29] == 3'b111) begin
                                if (led_cnt < LED_LIMIT) begin
                                    pix_we     <= 1'b1;
                                    pix_addr   <= led_cnt[AW-1:0];
                                    pix_bright <= word_next[28:24];
                                    pix_rgb    <= {word_next[7:0], word_next[15:8], word_next[23:16]};
                                end else begin
                                    overflow <= 1'b1;
                                end
                                if (led_cnt != LED_SAT) begin
                                    led_cnt <= led_cnt + 1'b1;
                                end
                            end else if (word_next == 32'd0) begin
                                frame_done <= 1'b1;
                                frame_leds <= led_cnt;
                                state      <= ST_IDLE;
                            end else begin
                                proto_err <= 1'b1;
                                zero_cnt  <= '0;
                                state     <= ST_HUNT;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (timeout_cnt == TO_LAST) begin
                        // sclk stalled: close the frame with the words completed so far
                        timeout_cnt <= '0;
                        frame_done  <= 1'b1;
                        frame_leds  <= led_cnt;
                        bit_cnt     <= '0;
                        shift_reg   <= '0;
                        zero_cnt    <= '0;
                        state       <= ST_HUNT;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apa102_strip_rx.sv
// Self-checking bench for apa102_strip_rx: fixed vectors, protocol corner
// cases and random frames compared against a word-level reference model.
module tb_apa102_strip_rx;

    localparam int NUM_LEDS = 64;
    localparam int TIMEOUT  = 4096;
    localparam int AW       = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sclk_in = 1'b0;
    logic          sdata_in = 1'b0;
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic [4:0]    pix_bright;
    logic [23:0]   pix_rgb;
    logic          frame_done;
    logic [AW:0]   frame_leds;
    logic          overflow;
    logic          proto_err;
    logic          synced;

    always #5 clk = ~clk;

    apa102_strip_rx #(.NUM_LEDS(NUM_LEDS), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .sclk_in(sclk_in), .sdata_in(sdata_in),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_bright(pix_bright), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .frame_leds(frame_leds), .overflow(overflow),
        .proto_err(proto_err), .synced(synced)
    );

    typedef struct {
        logic [31:0] word;
        logic [4:0]  bright;
        logic [23:0] rgb;
    } vec_t;

    vec_t        vt[6];
    int          checks = 0;
    int          failures = 0;

    logic [AW-1:0] cap_addr[$];
    logic [4:0]    cap_bright[$];
    logic [23:0]   cap_rgb[$];
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            done_base = 0;
    int            err_base = 0;
    logic [AW:0]   done_leds = '0;
    logic [31:0]   fw[$];

    always @(negedge clk) begin
        if (pix_we) begin
            cap_addr.push_back(pix_addr);
            cap_bright.push_back(pix_bright);
            cap_rgb.push_back(pix_rgb);
        end
        if (frame_done) begin
            done_cnt++;
            done_leds = frame_leds;
        end
        if (proto_err) err_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdata_in = b;
        repeat (3) @(negedge clk);
        sclk_in = 1'b1;
        repeat (3) @(negedge clk);
        sclk_in = 1'b0;
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic clear_cap();
        cap_addr.delete();
        cap_bright.delete();
        cap_rgb.delete();
        done_base = done_cnt;
        err_base  = err_cnt;
    endtask

    task automatic send_frame(input int lead, input int tail);
        send_zeros(lead);
        foreach (fw[i]) send_word(fw[i]);
        send_zeros(tail);
        idle(4);
    endtask

    // Reference model: what a complete frame of fw[] must produce.
    task automatic verify_frame(input string tag);
        int n, nw, exp_leds;
        logic [31:0] w;
        n        = fw.size();
        nw       = (n < NUM_LEDS) ? n : NUM_LEDS;
        exp_leds = (n > 127) ? 127 : n;
        check({tag, " writes"}, cap_addr.size(), nw);
        for (int i = 0; i < nw && i < cap_addr.size(); i++) begin
            w = fw[i];
            check($sformatf("%s addr[%0d]", tag, i), cap_addr[i], i);
            check($sformatf("%s bright[%0d]", tag, i), cap_bright[i], (w >> 24) & 32'h1f);
            check($sformatf("%s rgb[%0d]", tag, i), cap_rgb[i],
                  ((w & 32'hff) << 16) | (w & 32'hff00) | ((w >> 16) & 32'hff));
        end
        check({tag, " done"}, done_cnt - done_base, 1);
        check({tag, " leds"}, done_leds, exp_leds);
        check({tag, " overflow"}, overflow, (n > NUM_LEDS) ? 1 : 0);
        check({tag, " no err"}, err_cnt - err_base, 0);
    endtask

    task automatic fill_random(input int n);
        fw.delete();
        for (int i = 0; i < n; i++) fw.push_back({3'b111, 29'($urandom)});
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " pix_we"}, pix_we, 0);
        check({tag, " pix_addr"}, pix_addr, 0);
        check({tag, " pix_bright"}, pix_bright, 0);
        check({tag, " pix_rgb"}, pix_rgb, 0);
        check({tag, " frame_done"}, frame_done, 0);
        check({tag, " frame_leds"}, frame_leds, 0);
        check({tag, " overflow"}, overflow, 0);
        check({tag, " proto_err"}, proto_err, 0);
        check({tag, " synced"}, synced, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'hF0000F00, 5'h10, 24'h000F00};
        vt[1] = '{32'hF0070000, 5'h10, 24'h000007};
        vt[2] = '{32'hFF112233, 5'h1F, 24'h332211};
        vt[3] = '{32'hE0ABCDEF, 5'h00, 24'hEFCDAB};
        vt[4] = '{32'hE5000001, 5'h05, 24'h010000};
        vt[5] = '{32'hFA808000, 5'h1A, 24'h008080};

        reset = 1'b1;
        idle(3);
        check_outputs_zero("reset");
        reset = 1'b0;
        idle(2);

        // Two-word frame
        clear_cap();
        fw = '{32'hF0000F00, 32'hF0070000};
        send_frame(32, 32);
        verify_frame("t1");
        check("t1 synced", synced, 1);

        // Hand-computed vectors in one frame
        clear_cap();
        fw.delete();
        foreach (vt[i]) fw.push_back(vt[i].word);
        send_frame(8, 32);
        check("vec writes", cap_addr.size(), 6);
        for (int i = 0; i < 6 && i < cap_addr.size(); i++) begin
            check($sformatf("vec addr[%0d]", i), cap_addr[i], i);
            check($sformatf("vec bright[%0d]", i), cap_bright[i], vt[i].bright);
            check($sformatf("vec rgb[%0d]", i), cap_rgb[i], vt[i].rgb);
        end
        check("vec leds", done_leds, 6);

        // Full matrix frame, twice
        for (int r = 0; r < 2; r++) begin
            clear_cap();
            fill_random(NUM_LEDS);
            send_frame(64, 64);
            verify_frame($sformatf("t2.%0d", r));
            check("t2 synced", synced, 1);
        end

        // Overflowing frame, then a short frame that clears overflow
        clear_cap();
        fill_random(NUM_LEDS + 2);
        send_frame(32, 32);
        verify_frame("t3");
        clear_cap();
        fill_random(1);
        send_zeros(32);
        send_word(fw[0]);
        idle(4);
        check("t3 overflow cleared", overflow, 0);
        send_zeros(32);
        idle(4);
        verify_frame("t3b");

        // Malformed word mid-frame
        clear_cap();
        send_zeros(32);
        send_word(32'hF0000F00);
        send_word(32'h40FF00FF);
        idle(4);
        check("t4 proto_err", err_cnt - err_base, 1);
        check("t4 no done", done_cnt - done_base, 0);
        check("t4 synced low", synced, 0);
        check("t4 writes", cap_addr.size(), 1);
        send_zeros(31);
        idle(4);
        check("t4 synced after 31", synced, 0);
        send_zeros(1);
        idle(4);
        check("t4 synced after 32", synced, 1);

        // Random frames
        for (int r = 0; r < 6; r++) begin
            clear_cap();
            fill_random($urandom_range(1, 8));
            send_frame($urandom_range(0, 40), 32 + $urandom_range(0, 8));
            verify_frame($sformatf("rnd%0d", r));
        end

        // sclk stalls mid-word
        clear_cap();
        fill_random(5);
        send_zeros(32);
        foreach (fw[i]) send_word(fw[i]);
        for (int i = 0; i < 7; i++) send_bit(1'($urandom));
        idle(TIMEOUT - 100);
        check("t5 no early done", done_cnt - done_base, 0);
        check("t5 still synced", synced, 1);
        idle(200);
        check("t5 done", done_cnt - done_base, 1);
        check("t5 leds", done_leds, 5);
        check("t5 hunt", synced, 0);
        check("t5 writes", cap_addr.size(), 5);

        // Reset mid-frame, then a clean frame
        clear_cap();
        send_zeros(32);
        send_word(32'hF0000F00);
        send_word(32'hF0070000);
        for (int i = 31; i >= 12; i--) send_bit(vt[2].word[i]);
        reset = 1'b1;
        idle(2);
        check_outputs_zero("t6 reset");
        check("t6 no done", done_cnt - done_base, 0);
        reset = 1'b0;
        idle(2);
        clear_cap();
        fw = '{32'hF0000F00, 32'hF0070000};
        send_frame(32, 32);
        verify_frame("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
